// File: rtl/ysyx_22040383_ifu_pf.sv
// Prefetching instruction fetch unit: one outstanding imem request, {pc, instr} FIFO towards ID.
// Optional IFU_MISALIGN_CHECK_EN: a misaligned redirect target yields one exception entry and halts fetch.
module ysyx_22040383_ifu_pf #(
  parameter int unsigned     XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(64'h8000_0000),
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter int unsigned     MEM_W      = 64
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [XLEN-1:0]  imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [MEM_W-1:0] imem_resp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_pc_plus_4,
  output logic [31:0]      out_instr,
  output logic             out_exc
);
  localparam int unsigned     PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned     CW      = PW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] FOUR    = XLEN'(4);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
`ifdef IFU_MISALIGN_CHECK_EN
    S_DROP,
    S_IDLE_EXC
`else
    S_DROP
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            run_q;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] fifo_pc_q [FIFO_DEPTH];
  logic [31:0]     fifo_instr_q [FIFO_DEPTH];

  logic            req_fire, pop, push, in_flight;
  logic [XLEN-1:0] push_pc, redir_pc;
  logic [31:0]     push_instr, resp_instr;

`ifdef IFU_MISALIGN_CHECK_EN
  logic fifo_exc_q [FIFO_DEPTH];
  logic exc_push_q, exc_push_d, stale_q, stale_d, push_exc, misaligned;
  assign redir_pc   = redirect_pc;
  assign misaligned = redirect_pc[1:0] != 2'b00;
`else
  logic unused_redir_lo;
  assign redir_pc        = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redir_lo = ^redirect_pc[1:0];
`endif

  assign imem_req_valid = run_q && (state_q == S_REQ) && (count_q < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_instr     = req_pc_q[2] ? imem_resp_data[63:32] : imem_resp_data[31:0];

  assign out_valid     = count_q != '0;
  assign pop           = out_valid && out_ready;
  assign out_pc        = out_valid ? fifo_pc_q[rd_ptr_q] : '0;
  assign out_pc_plus_4 = out_valid ? fifo_pc_q[rd_ptr_q] + FOUR : '0;
  assign out_instr     = out_valid ? fifo_instr_q[rd_ptr_q] : '0;
`ifdef IFU_MISALIGN_CHECK_EN
  assign out_exc       = out_valid ? fifo_exc_q[rd_ptr_q] : 1'b0;
`else
  assign out_exc       = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    push_pc    = req_pc_q;
    push_instr = resp_instr;
    in_flight  = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    exc_push_d = 1'b0;
    stale_d    = stale_q;
    push_exc   = 1'b0;
`endif
    case (state_q)
      S_REQ: if (req_fire) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + FOUR;
        state_d    = S_WAIT;
      end
      S_WAIT: if (imem_resp_valid) begin
        push    = 1'b1;
        state_d = S_REQ;
      end
      S_DROP: if (imem_resp_valid) state_d = S_REQ;
`ifdef IFU_MISALIGN_CHECK_EN
      S_IDLE_EXC: if (imem_resp_valid) stale_d = 1'b0;
`endif
      default: state_d = S_REQ;
    endcase
`ifdef IFU_MISALIGN_CHECK_EN
    // fetch_pc_q still holds the misaligned target while the exception entry is pushed
    if (exc_push_q) begin
      push       = 1'b1;
      push_pc    = fetch_pc_q;
      push_instr = '0;
      push_exc   = 1'b1;
    end
`endif
    if (redirect_valid) begin
      push       = 1'b0;
      fetch_pc_d = redir_pc;
      in_flight  = ((state_q == S_REQ) && req_fire)
                || (((state_q == S_WAIT) || (state_q == S_DROP)) && !imem_resp_valid);
`ifdef IFU_MISALIGN_CHECK_EN
      in_flight  = in_flight || ((state_q == S_IDLE_EXC) && stale_q && !imem_resp_valid);
`endif
      state_d    = in_flight ? S_DROP : S_REQ;
`ifdef IFU_MISALIGN_CHECK_EN
      if (misaligned) begin
        state_d    = S_IDLE_EXC;
        exc_push_d = 1'b1;
        stale_d    = in_flight;
      end
`endif
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      run_q      <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
`ifdef IFU_MISALIGN_CHECK_EN
      exc_push_q <= 1'b0;
      stale_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      run_q      <= 1'b1;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
`ifdef IFU_MISALIGN_CHECK_EN
      exc_push_q <= exc_push_d;
      stale_q    <= stale_d;
`endif
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]    <= push_pc;
      fifo_instr_q[wr_ptr_q] <= push_instr;
`ifdef IFU_MISALIGN_CHECK_EN
      fifo_exc_q[wr_ptr_q]   <= push_exc;
`endif
    end
  end

endmodule

// File: doc/ysyx_22040383_ifu_pf.md
Name: ysyx_22040383_ifu_pf

Overview:
Parametrised prefetching instruction fetch unit; successor to the single-cycle DPI fetch path.
- Issues instruction-memory requests over a valid/ready bus and tolerates variable response latency.
- Buffers fetched {pc, instr} pairs in a FIFO and presents them to ID over a valid/ready handshake.
- Handles branch/jump redirects, including discarding responses already in flight.

Parameters:
XLEN, 64, address/PC width
RESET_PC, 64'h80000000, first fetch address after reset
FIFO_DEPTH, 4, prefetch buffer entries (power of two, >=2)
MEM_W, 64, memory response width; fixed at 64 (two instructions per word)

Ports:
sys_clk  in  1  clock
sys_rst  in  1  reset, asynchronous, active-low
redirect_valid  in  1  redirect request from EX (pc_sel replacement)
redirect_pc  in  XLEN  redirect target
imem_req_valid  out  1  memory request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch PC (memory returns the enclosing 8-byte word)
imem_resp_valid  in  1  response data valid
imem_resp_data  in  MEM_W  8-byte aligned doubleword
out_valid  out  1  FIFO head valid
out_ready  in  1  ID accepts head (stall = !out_ready)
out_pc  out  XLEN  PC of head instruction
out_pc_plus_4  out  XLEN  out_pc+4, wraps modulo 2^XLEN
out_instr  out  32  instruction
out_exc  out  1  misaligned-fetch flag (optional feature; 0 otherwise)

Behaviour:
Reset (sys_rst low, async):
- fetch_pc=RESET_PC; FIFO empty; out_valid=0; imem_req_valid=0; state=REQ.
- Outputs out_pc, out_pc_plus_4, out_instr, out_exc read 0 while empty.

States:
- REQ: assert imem_req_valid when count < FIFO_DEPTH. Buffer slot is reserved at issue. Addr = fetch_pc, held stable until accepted. On valid&&ready: latch req_pc=fetch_pc, fetch_pc += 4, -> WAIT.
- WAIT: one request outstanding, any latency >= 1 cycle. On imem_resp_valid: push {req_pc, instr} to FIFO, -> REQ. Next request issues the following cycle at the earliest.
- DROP: stale request outstanding. On imem_resp_valid: discard the data, -> REQ.

Instruction select: instr = req_pc[2] ? data[63:32] : data[31:0].

FIFO:
- Push on response; pop on out_valid && out_ready.
- Push and pop in the same cycle leaves count unchanged, including when full.
- out_* is driven directly from the head entry (no output register).
- Pointers wrap modulo FIFO_DEPTH.

Redirect (redirect_valid=1, takes priority over every other event in that cycle):
- FIFO flushed (count=0); a same-cycle pop still counts as a completed transfer.
- fetch_pc <= redirect_pc.
- REQ with request not yet accepted: request withdrawn (imem_req_valid may drop without handshake); stay REQ.
- REQ with request accepted this cycle, or WAIT without response this cycle: -> DROP.
- WAIT/DROP with response this cycle: response discarded; -> REQ.
- DROP with redirect: stays DROP; newer target replaces fetch_pc.

Other rules:
- Back-to-back redirects: last one wins.
- Memory must not return a response without an outstanding request.

Optional Feature:
IFU_MISALIGN_CHECK_EN
- Defined: a redirect_pc with [1:0] != 0 issues no memory request. The next cycle pushes one entry {redirect_pc, instr=32'h0, out_exc=1}. Fetch then halts (state IDLE_EXC, imem_req_valid=0) until the next redirect.
- Undefined: redirect_pc[1:0] forced to 2'b00; out_exc tied 0; no IDLE_EXC state.

Test Plan:
1. Reset release, out_ready=1, 1-cycle memory latency -> requests at 0x80000000, 0x80000004, 0x80000008. Outputs in order; instr from data[31:0], data[63:32], data[31:0]; out_pc_plus_4 = 0x80000004, 0x80000008, 0x8000000C.
2. out_ready=0 for 20 cycles, FIFO_DEPTH=4 -> exactly 4 entries buffered, imem_req_valid stays 0 afterwards. Release out_ready -> 4 pops in 4 cycles, then fetch resumes at 0x80000010.
3. Redirect to 0x80000100 while WAIT with 5-cycle latency -> stale response discarded. Next out_pc = 0x80000100; no 0x8000000x entry appears after the redirect.
4. Redirect in the same cycle as imem_resp_valid and a full FIFO pop -> FIFO empty next cycle, response dropped, request to the redirect target next cycle.
5. imem_req_ready held 0 for 3 cycles, then redirect -> address switches to the new target with no handshake. On ready, exactly one request is accepted at the new PC.
6. (IFU_MISALIGN_CHECK_EN) redirect to 0x80000102 -> one entry {pc=0x80000102, instr=0, out_exc=1}, no request issued. Redirect to 0x80000200 -> normal fetch resumes.
